// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: FSM state encoding,
// word-offset constant and the backing-array index width helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte address bits below the word index; word access only.
    localparam int WORD_OFFSET_BITS = 2;

    // Number of word-index bits needed to address a backing array of 'words' entries.
    function automatic int index_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Backing store for the responder: synchronous write, combinational read,
// contents are never reset so they survive a responder reset.
module main_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Write port: one word per cycle when we is asserted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/main_mem_responder.sv
// Responder end of the cache <-> main-memory interface.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready, and the
// response outputs are held stable until that edge. One request outstanding.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_WORDS     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int IDX_W   = index_width(MEM_WORDS);
    localparam int WADDR_W = ADDR_WIDTH - WORD_OFFSET_BITS;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [WADDR_W-1:0]    waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  in_range;
    logic                  unused_addr_bits;

    // Byte-offset bits never select anything.
    assign unused_addr_bits = ^req_addr[WORD_OFFSET_BITS-1:0];

    // Any set bit above the index field puts the word beyond the array.
    assign in_range = ~|waddr_q[WADDR_W-1:IDX_W];
    assign mem_idx  = waddr_q[IDX_W-1:0];

    main_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // Next-state: accept in IDLE, count latency in WAIT, perform access on WAIT exit, hold in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    waddr_d = req_addr[ADDR_WIDTH-1:WORD_OFFSET_BITS];
                    wdata_d = req_wdata;
                    cnt_d   = req_we ? WR_LOAD : RD_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RESP;
                    if (in_range) begin
                        err_d = 1'b0;
                        if (we_q) begin
                            mem_we  = 1'b1;
                            rdata_d = '0;
                        end else begin
                            rdata_d = mem_rdata;
                        end
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: a default-latency instance (index 0) and a
// latency-1 instance (index 1), checked against a word-addressed reference model.
module tb_main_mem_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n      [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic          req_we     [2];
    logic [AW-1:0] req_addr   [2];
    logic [DW-1:0] req_wdata  [2];
    logic          resp_valid [2];
    logic          resp_ready [2];
    logic [DW-1:0] resp_rdata [2];
    logic          resp_err   [2];
    logic          busy       [2];

    main_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW),
        .READ_LATENCY(4), .WRITE_LATENCY(2)
    ) dut0 (
        .clk(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    main_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW),
        .READ_LATENCY(1), .WRITE_LATENCY(1)
    ) dut1 (
        .clk(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    int lat_rd [2] = '{4, 1};
    int lat_wr [2] = '{2, 1};

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [int];   // key = dut*2^20 + word index
    int pool [17];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [AW-1:0] a);
        logic [AW-1:0] lim;
        lim = AW'(MW * 4);
        return a < lim;
    endfunction

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, "_req_ready"}, 64'(req_ready[d]), 64'd1);
        check({tag, "_resp_valid"}, 64'(resp_valid[d]), 64'd0);
        check({tag, "_rdata"}, 64'(resp_rdata[d]), 64'd0);
        check({tag, "_err"}, 64'(resp_err[d]), 64'd0);
        check({tag, "_busy"}, 64'(busy[d]), 64'd0);
    endtask

    // ---------------- driver ----------------
    // One complete transaction; hold = cycles of resp_ready back-pressure,
    // junk = drive a conflicting request while the response is held.
    task automatic do_txn(input int d, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int hold, input bit junk);
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] held_rd;
        logic          held_err;
        logic          exp_err;
        bit            known;
        int            key;
        int            lat;
        int            n;

        exp_err = !in_rng(addr);
        exp_rd  = '0;
        known   = 1'b1;
        if (!exp_err) begin
            key = d * (1 << 20) + int'(addr[AW-1:2]);
            if (we) model_mem[key] = wdata;
            else if (model_mem.exists(key)) exp_rd = model_mem[key];
            else known = 1'b0;
        end
        exp_q.push_back(exp_rd);
        lat = we ? lat_wr[d] : lat_rd[d];

        @(negedge clk);
        check("idle_ready", 64'(req_ready[d]), 64'd1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        resp_ready[d] = (hold == 0);

        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        check("wait_busy", 64'(busy[d]), 64'd1);
        check("wait_ready", 64'(req_ready[d]), 64'd0);

        n = 0;
        while (!resp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_rd = exp_q.pop_front();
        if (!resp_valid[d]) begin
            check("resp_timeout", 64'(resp_valid[d]), 64'd1);
            resp_ready[d] = 1'b1;
            return;
        end
        check(we ? "wr_latency" : "rd_latency", 64'(n), 64'(lat));
        if (known) check(we ? "wr_rdata" : "rd_rdata", 64'(resp_rdata[d]), 64'(exp_rd));
        check("resp_err", 64'(resp_err[d]), 64'(exp_err));
        held_rd  = resp_rdata[d];
        held_err = resp_err[d];

        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                req_valid[d] = 1'b1;
                req_we[d]    = 1'b1;
                req_addr[d]  = addr;
                req_wdata[d] = ~wdata;
            end
            @(negedge clk);
            check("hold_valid", 64'(resp_valid[d]), 64'd1);
            check("hold_rdata", 64'(resp_rdata[d]), 64'(held_rd));
            check("hold_err", 64'(resp_err[d]), 64'(held_err));
            check("hold_ready", 64'(req_ready[d]), 64'd0);
        end

        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        check("post_valid", 64'(resp_valid[d]), 64'd0);
        check("post_ready", 64'(req_ready[d]), 64'd1);
        check("post_busy", 64'(busy[d]), 64'd0);
        check("post_rdata_held", 64'(resp_rdata[d]), 64'(held_rd));
        check("post_err_held", 64'(resp_err[d]), 64'(held_err));
    endtask

    task automatic rand_txn(input int d);
        logic [AW-1:0] a;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) a = AW'(MW * 4) + AW'($urandom_range(0, 4095));
        else if (r == 1) a = $urandom | AW'(MW * 4);
        else a = AW'(pool[$urandom_range(0, 16)] * 4 + $urandom_range(0, 3));
        do_txn(d, 1'($urandom_range(0, 1)), a, $urandom,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
               1'($urandom_range(0, 1)));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d]      = 1'b0;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            resp_ready[d] = 1'b1;
        end
        for (int i = 0; i < 16; i++) pool[i] = i;
        pool[16] = MW - 1;

        #1;
        check_reset_outputs(0, "rst0");
        check_reset_outputs(1, "rst1");
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Give every pool word a known value in both instances.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 17; i++)
                do_txn(d, 1'b1, AW'(pool[i] * 4), $urandom, 0, 1'b0);

        // Reset in WAIT drops a pending write.
        do_txn(0, 1'b1, 32'h10, 32'hA5A5_0010, 0, 1'b0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("pre_rst_busy", 64'(busy[0]), 64'd1);
        rst_n[0] = 1'b0;
        #1;
        check_reset_outputs(0, "midwait_rst");
        @(negedge clk);
        check_reset_outputs(0, "midwait_rst_hold");
        rst_n[0] = 1'b1;
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        // Write then read, default latencies.
        do_txn(0, 1'b1, 32'h40, 32'h1234_5678, 0, 1'b0);
        do_txn(0, 1'b0, 32'h40, 32'h0, 0, 1'b0);
        // Unaligned read hits the same word.
        do_txn(0, 1'b0, 32'h43, 32'h0, 0, 1'b0);
        // Range boundary.
        do_txn(0, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
        do_txn(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 0, 1'b0);
        do_txn(0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        do_txn(0, 1'b0, 32'hFFC, 32'h0, 0, 1'b0);
        // Back-pressure with an ignored request during RESP.
        do_txn(0, 1'b0, 32'h40, 32'h0, 5, 1'b1);
        do_txn(0, 1'b0, 32'h40, 32'h0, 0, 1'b0);

        // Latency-1 instance directed and random.
        do_txn(1, 1'b1, 32'h40, 32'h1234_5678, 0, 1'b0);
        do_txn(1, 1'b0, 32'h43, 32'h0, 2, 1'b1);
        for (int i = 0; i < 100; i++) rand_txn(1);
        for (int i = 0; i < 40; i++) rand_txn(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
